// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the board-side IO responder:
//   - sub-address codes for the LED, switch and tube request channels
//   - the active-low seven-segment glyph table for hex digits 0..F
// No ports (package).
// -----------------------------------------------------------------------------
package io_pkg;

  // LED channel sub-addresses
  localparam logic [1:0] LED_LO = 2'd0;
  localparam logic [1:0] LED_HI = 2'd1;

  // Switch channel sub-addresses
  localparam logic [1:0] SW_LO = 2'd0;
  localparam logic [1:0] SW_HI = 2'd1;

  // Tube channel sub-addresses
  localparam logic [1:0] TUBE_LO = 2'd0;
  localparam logic [1:0] TUBE_HI = 2'd1;
  localparam logic [1:0] TUBE_EN = 2'd2;
  localparam logic [1:0] TUBE_DP = 2'd3;

  // Active-low {g,f,e,d,c,b,a} patterns; element [n] is the glyph for hex n.
  // The decimal point is not part of the table and is added by the scanner.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/io_responder_if.sv
// -----------------------------------------------------------------------------
// io_responder_if
// CPU-side IO request bundle: LED write, switch read and tube write channels.
//   master : the CPU (drives strobes, addresses and write data; reads switch data)
//   slave  : io_responder (returns oSwitchDataRead)
// Member names match the CPU's IO port names so the top level wires one-to-one.
// -----------------------------------------------------------------------------
interface io_responder_if;
  logic        iDoLedWrite;
  logic [1:0]  iLightAddress;
  logic [15:0] iLightDataToWrite;
  logic        iDoSwitchRead;
  logic [1:0]  iSwirchAddress;
  logic [15:0] oSwitchDataRead;
  logic        iDoTubeWrite;
  logic [1:0]  iTubeAddress;
  logic [15:0] iTubeDataToWrite;

  modport master (
    output iDoLedWrite, iLightAddress, iLightDataToWrite,
    output iDoSwitchRead, iSwirchAddress,
    output iDoTubeWrite, iTubeAddress, iTubeDataToWrite,
    input  oSwitchDataRead
  );

  modport slave (
    input  iDoLedWrite, iLightAddress, iLightDataToWrite,
    input  iDoSwitchRead, iSwirchAddress,
    input  iDoTubeWrite, iTubeAddress, iTubeDataToWrite,
    output oSwitchDataRead
  );
endinterface

// File: rtl/hex_to_seven_segment.sv
// -----------------------------------------------------------------------------
// hex_to_seven_segment
// Combinational hex-digit to active-low seven-segment decoder.
//   iHex     in  4  hex digit 0..F
//   oSegment out 7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_seven_segment
  import io_pkg::*;
(
  input  logic [3:0] iHex,
  output logic [6:0] oSegment
);

  assign oSegment = GLYPH_TABLE[iHex];

endmodule

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
// Board-side responder for the CPU's LED write, switch read and tube write
// channels. Holds LED and tube state, synchronizes the switches, and scans the
// 8-digit multiplexed seven-segment tube.
//   iCpuClock    in   1   system clock, rising edge
//   iCpuReset    in   1   asynchronous active-low reset
//   ioBus        slave    CPU IO request channels (io_responder_if)
//   iSwitch      in   24  raw board switches, asynchronous
//   oLed         out  24  board LEDs, active-high
//   oTubeSegment out  8   {dp,g,f,e,d,c,b,a}, active-low
//   oTubeSelect  out  8   digit enables, active-low, bit 0 = rightmost digit
// -----------------------------------------------------------------------------
module io_responder
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic              iCpuClock,
  input  logic              iCpuReset,
  io_responder_if.slave     ioBus,
  input  logic [23:0]       iSwitch,
  output logic [23:0]       oLed,
  output logic [7:0]        oTubeSegment,
  output logic [7:0]        oTubeSelect
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

  logic [23:0]       swMeta_r, swSync_r;
  logic [23:0]       led_r, ledNext_s;
  logic [31:0]       tubeValue_r, tubeValueNext_s;
  logic [7:0]        enMask_r, enMaskNext_s;
  logic [7:0]        dpMask_r, dpMaskNext_s;
  logic [SCAN_W-1:0] prescale_r, prescaleNext_s;
  logic [2:0]        digitIdx_r, digitIdxNext_s;
  logic [7:0]        tubeSelect_r, tubeSelectNext_s;
  logic [7:0]        tubeSegment_r, tubeSegmentNext_s;
  logic [3:0]        nibble_s;
  logic [6:0]        glyph_s;
  logic [15:0]       switchRead_s;

  // State register: all board-side state, plus the registered tube outputs.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      swMeta_r      <= 24'h000000;
      swSync_r      <= 24'h000000;
      led_r         <= 24'h000000;
      tubeValue_r   <= 32'h00000000;
      enMask_r      <= 8'hFF;
      dpMask_r      <= 8'h00;
      prescale_r    <= {SCAN_W{1'b0}};
      digitIdx_r    <= 3'd0;
      tubeSelect_r  <= 8'hFE;
      tubeSegment_r <= 8'hC0;
    end else begin
      swMeta_r      <= iSwitch;
      swSync_r      <= swMeta_r;
      led_r         <= ledNext_s;
      tubeValue_r   <= tubeValueNext_s;
      enMask_r      <= enMaskNext_s;
      dpMask_r      <= dpMaskNext_s;
      prescale_r    <= prescaleNext_s;
      digitIdx_r    <= digitIdxNext_s;
      tubeSelect_r  <= tubeSelectNext_s;
      tubeSegment_r <= tubeSegmentNext_s;
    end
  end

  // LED next state: addresses 2/3 leave the LEDs untouched.
  always_comb begin
    ledNext_s = led_r;
    if (ioBus.iDoLedWrite) begin
      case (ioBus.iLightAddress)
        LED_LO:  ledNext_s[15:0]  = ioBus.iLightDataToWrite;
        LED_HI:  ledNext_s[23:16] = ioBus.iLightDataToWrite[7:0];
        default: ledNext_s        = led_r;
      endcase
    end else begin
      ledNext_s = led_r;
    end
  end

  // Tube value and mask next state.
  always_comb begin
    tubeValueNext_s = tubeValue_r;
    enMaskNext_s    = enMask_r;
    dpMaskNext_s    = dpMask_r;
    if (ioBus.iDoTubeWrite) begin
      case (ioBus.iTubeAddress)
        TUBE_LO: tubeValueNext_s[15:0]  = ioBus.iTubeDataToWrite;
        TUBE_HI: tubeValueNext_s[31:16] = ioBus.iTubeDataToWrite;
        TUBE_EN: enMaskNext_s           = ioBus.iTubeDataToWrite[7:0];
        TUBE_DP: dpMaskNext_s           = ioBus.iTubeDataToWrite[7:0];
        default: tubeValueNext_s        = tubeValue_r;
      endcase
    end else begin
      tubeValueNext_s = tubeValue_r;
    end
  end

  // Scan next state: prescaler 0..SCAN_DIV-1, digit index wraps naturally at 8.
  always_comb begin
    if (prescale_r == SCAN_LAST) begin
      prescaleNext_s = {SCAN_W{1'b0}};
      digitIdxNext_s = digitIdx_r + 3'd1;
    end else begin
      prescaleNext_s = prescale_r + SCAN_ONE;
      digitIdxNext_s = digitIdx_r;
    end
  end

  // The tube outputs are built from next-state values so that a write and a
  // digit advance landing on the same edge are both visible straight away.
  assign nibble_s = tubeValueNext_s[{digitIdxNext_s, 2'b00} +: 4];

  hex_to_seven_segment uGlyph (
    .iHex     (nibble_s),
    .oSegment (glyph_s)
  );

  // Tube output decode: disabled digits blank both select and segments.
  always_comb begin
    if (enMaskNext_s[digitIdxNext_s]) begin
      tubeSelectNext_s  = ~(8'h01 << digitIdxNext_s);
      tubeSegmentNext_s = {~dpMaskNext_s[digitIdxNext_s], glyph_s};
    end else begin
      tubeSelectNext_s  = 8'hFF;
      tubeSegmentNext_s = 8'hFF;
    end
  end

  // Switch read data: combinational so the single-cycle CPU sees it the same cycle.
  always_comb begin
    switchRead_s = 16'h0000;
    if (ioBus.iDoSwitchRead) begin
      case (ioBus.iSwirchAddress)
        SW_LO:   switchRead_s = swSync_r[15:0];
        SW_HI:   switchRead_s = {8'h00, swSync_r[23:16]};
        default: switchRead_s = 16'h0000;
      endcase
    end else begin
      switchRead_s = 16'h0000;
    end
  end

  assign ioBus.oSwitchDataRead = switchRead_s;
  assign oLed         = led_r;
  assign oTubeSelect  = tubeSelect_r;
  assign oTubeSegment = tubeSegment_r;

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
// Self-checking bench for io_responder with a fast scan (SCAN_DIV=4).
// The reference model tracks LED/tube contents and masks, counts clock edges
// since reset to derive which digit is lit, and remembers switch samples by age.
// -----------------------------------------------------------------------------
module tb_io_responder;

  localparam int SCAN_DIV = 4;
  localparam int SCAN_W   = 3;

  logic        clk  = 1'b0;
  logic        rstN = 1'b1;
  logic [23:0] sw   = 24'h000000;
  logic [23:0] led;
  logic [7:0]  seg;
  logic [7:0]  sel;

  io_responder_if bus ();

  io_responder #(.SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
    .iCpuClock    (clk),
    .iCpuReset    (rstN),
    .ioBus        (bus),
    .iSwitch      (sw),
    .oLed         (led),
    .oTubeSegment (seg),
    .oTubeSelect  (sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [23:0] mLed;
  logic [31:0] mValue;
  logic [7:0]  mEn;
  logic [7:0]  mDp;
  logic [23:0] mSwAge1;   // switch value sampled at the most recent edge
  logic [23:0] mSwAge2;   // switch value sampled one edge before that
  int          mTicks;    // rising edges since reset release

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int curDigit();
    return (mTicks / SCAN_DIV) % 8;
  endfunction

  function automatic logic [7:0] expSel();
    int d = curDigit();
    if (mEn[d]) return ~(8'h01 << d);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] expSeg();
    int d = curDigit();
    logic [7:0] g;
    if (!mEn[d]) return 8'hFF;
    g = glyph[mValue[4*d +: 4]];
    g[7] = ~mDp[d];
    return g;
  endfunction

  function automatic logic [15:0] expRead();
    if (!bus.iDoSwitchRead) return 16'h0000;
    case (bus.iSwirchAddress)
      2'd0:    return mSwAge2[15:0];
      2'd1:    return {8'h00, mSwAge2[23:16]};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic idle();
    bus.iDoLedWrite       = 1'b0;
    bus.iLightAddress     = 2'd0;
    bus.iLightDataToWrite = 16'h0000;
    bus.iDoSwitchRead     = 1'b0;
    bus.iSwirchAddress    = 2'd0;
    bus.iDoTubeWrite      = 1'b0;
    bus.iTubeAddress      = 2'd0;
    bus.iTubeDataToWrite  = 16'h0000;
  endtask

  task automatic modelReset();
    mLed    = 24'h000000;
    mValue  = 32'h00000000;
    mEn     = 8'hFF;
    mDp     = 8'h00;
    mSwAge1 = 24'h000000;
    mSwAge2 = 24'h000000;
    mTicks  = 0;
  endtask

  // One rising edge: apply the held requests to the model, then check outputs.
  task automatic clockEdge(input string tag);
    @(posedge clk);
    if (bus.iDoLedWrite) begin
      if (bus.iLightAddress == 2'd0) mLed[15:0] = bus.iLightDataToWrite;
      else if (bus.iLightAddress == 2'd1) mLed[23:16] = bus.iLightDataToWrite[7:0];
    end
    if (bus.iDoTubeWrite) begin
      case (bus.iTubeAddress)
        2'd0:    mValue[15:0]  = bus.iTubeDataToWrite;
        2'd1:    mValue[31:16] = bus.iTubeDataToWrite;
        2'd2:    mEn           = bus.iTubeDataToWrite[7:0];
        default: mDp           = bus.iTubeDataToWrite[7:0];
      endcase
    end
    mSwAge2 = mSwAge1;
    mSwAge1 = sw;
    mTicks++;
    #1;
    checkValue({tag, "_led"}, {8'h00, led}, {8'h00, mLed});
    checkValue({tag, "_sel"}, {24'h0, sel}, {24'h0, expSel()});
    checkValue({tag, "_seg"}, {24'h0, seg}, {24'h0, expSeg()});
  endtask

  task automatic checkRead(input string tag);
    #1;
    checkValue(tag, {16'h0, bus.oSwitchDataRead}, {16'h0, expRead()});
  endtask

  // Assert reset away from the clock edge, check outputs asynchronously, release.
  task automatic doReset(input string tag);
    rstN = 1'b0;
    bus.iDoSwitchRead  = 1'b1;
    bus.iSwirchAddress = 2'd0;
    #2;
    checkValue({tag, "_rst_led"}, {8'h00, led}, 32'h0);
    checkValue({tag, "_rst_sel"}, {24'h0, sel}, 32'hFE);
    checkValue({tag, "_rst_seg"}, {24'h0, seg}, 32'hC0);
    checkValue({tag, "_rst_rd"}, {16'h0, bus.oSwitchDataRead}, 32'h0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic writeLed(input logic [1:0] a, input logic [15:0] d);
    bus.iDoLedWrite = 1'b1; bus.iLightAddress = a; bus.iLightDataToWrite = d;
    clockEdge("ledw");
    idle();
  endtask

  task automatic writeTube(input logic [1:0] a, input logic [15:0] d);
    bus.iDoTubeWrite = 1'b1; bus.iTubeAddress = a; bus.iTubeDataToWrite = d;
    clockEdge("tubew");
    idle();
  endtask

  initial begin
    idle();
    modelReset();
    #1;
    doReset("init");
    idle();
    checkRead("init_rd_idle");

    // LED writes
    writeLed(2'd0, 16'hA5A5);
    writeLed(2'd1, 16'h12C3);
    checkValue("led_after_hi", {8'h00, led}, 32'hC3A5A5);
    writeLed(2'd2, 16'hFFFF);
    checkValue("led_addr2_ignored", {8'h00, led}, 32'hC3A5A5);

    // Switch synchronizer and read decode
    sw = 24'h3C1234;
    for (int i = 0; i < 3; i++) clockEdge("swsync");
    bus.iDoSwitchRead = 1'b1; bus.iSwirchAddress = 2'd0; checkRead("sw_rd0");
    checkValue("sw_rd0_const", {16'h0, bus.oSwitchDataRead}, 32'h1234);
    bus.iSwirchAddress = 2'd1; checkRead("sw_rd1");
    checkValue("sw_rd1_const", {16'h0, bus.oSwitchDataRead}, 32'h003C);
    bus.iSwirchAddress = 2'd3; checkRead("sw_rd3");
    bus.iDoSwitchRead = 1'b0; bus.iSwirchAddress = 2'd0; checkRead("sw_rd_off");
    idle();

    // Tube scan from a clean reset
    doReset("scan");
    idle();
    writeTube(2'd0, 16'h89AB);
    writeTube(2'd1, 16'h0000);
    checkValue("scan_d0_seg", {24'h0, seg}, 32'h83);
    checkValue("scan_d0_sel", {24'h0, sel}, 32'hFE);
    while (mTicks < 6) clockEdge("scan");
    checkValue("scan_d1_seg", {24'h0, seg}, 32'h88);
    checkValue("scan_d1_sel", {24'h0, sel}, 32'hFD);
    while (mTicks < 32) clockEdge("scan");
    checkValue("scan_wrap_sel", {24'h0, sel}, 32'hFE);

    // Enable and decimal-point masks
    writeTube(2'd2, 16'h0001);
    writeTube(2'd3, 16'h0001);
    for (int i = 0; i < 32; i++) begin
      clockEdge("mask");
      if (curDigit() == 0) checkValue("mask_dp_seg", {24'h0, seg}, 32'h03);
      else checkValue("mask_blank", {16'h0, sel, seg}, 32'hFFFF);
    end

    // Reset in the middle of the scan with LEDs lit
    writeTube(2'd2, 16'h00FF);
    writeLed(2'd0, 16'hBEEF);
    while (curDigit() != 5) clockEdge("pre_rst");
    doReset("midscan");
    idle();
    clockEdge("post_rst");
    checkValue("post_rst_sel", {24'h0, sel}, 32'hFE);

    // Randomized traffic on all three channels
    for (int c = 0; c < 800; c++) begin
      bus.iDoLedWrite       = ($urandom_range(0, 3) == 0);
      bus.iLightAddress     = 2'($urandom_range(0, 3));
      bus.iLightDataToWrite = 16'($urandom);
      bus.iDoTubeWrite      = ($urandom_range(0, 2) == 0);
      bus.iTubeAddress      = 2'($urandom_range(0, 3));
      bus.iTubeDataToWrite  = 16'($urandom);
      if (bus.iTubeAddress == 2'd2 && $urandom_range(0, 1) == 1) bus.iTubeDataToWrite = 16'h00FF;
      bus.iDoSwitchRead     = ($urandom_range(0, 1) == 1);
      bus.iSwirchAddress    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) sw = 24'($urandom);
      checkRead("rnd_rd");
      if (c == 400) begin
        doReset("rnd");
        idle();
      end else begin
        clockEdge("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
